// File: rtl/odd_count_checker_if.sv
// Bus between the odd counter stage and its checker: sampled count plus the
// checker's status and tally outputs.
interface odd_count_checker_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic [WIDTH-1:0] count;
    logic             clr;
    logic             locked;
    logic             err;
    logic             err_pulse;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [WIDTH-1:0] last_good;

    modport master (
        output in_valid, count, clr,
        input  locked, err, err_pulse, match_cnt, err_cnt, last_good
    );

    modport slave (
        input  in_valid, count, clr,
        output locked, err, err_pulse, match_cnt, err_cnt, last_good
    );
endinterface

// File: rtl/odd_count_checker.sv
// Monitors an odd counter: locks on the first odd sample, then requires each
// qualified sample to equal the previous one plus STEP (mod 2^WIDTH).
module odd_count_checker #(
    parameter int WIDTH  = 32,
    parameter int STEP   = 2,
    parameter int CNT_W  = 16,
    parameter bit RESYNC = 1'b1
) (
    input  logic                clk,
    input  logic                rst_l,
    odd_count_checker_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] STEP_W  = WIDTH'(STEP);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [WIDTH-1:0] expected;
    logic             locked;
    logic             err;
    logic             err_pulse;
    logic [CNT_W-1:0] match_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic [WIDTH-1:0] last_good;

    logic is_odd;
    logic is_hit;

    // An even value never matches, even if STEP would make expected even.
    assign is_odd = bus.count[0];
    assign is_hit = is_odd && (bus.count == expected);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

    // NOTE: all state below uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            expected  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_pulse <= 1'b0;
            match_cnt <= '0;
            err_cnt   <= '0;
            last_good <= '0;
        end else if (bus.clr) begin
            state     <= IDLE;
            expected  <= '0;
            locked    <= 1'b0;
            err       <= 1'b0;
            err_pulse <= 1'b0;
            match_cnt <= '0;
            err_cnt   <= '0;
            last_good <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (bus.in_valid) begin
                unique case (state)
                    IDLE: begin
                        if (is_odd) begin
                            state     <= TRACK;
                            locked    <= 1'b1;
                            expected  <= bus.count + STEP_W;
                            last_good <= bus.count;
                        end else begin
                            err       <= 1'b1;
                            err_pulse <= 1'b1;
                            err_cnt   <= sat_inc(err_cnt);
                        end
                    end
                    TRACK: begin
                        if (is_hit) begin
                            match_cnt <= sat_inc(match_cnt);
                            expected  <= expected + STEP_W;
                            last_good <= bus.count;
                        end else begin
                            err       <= 1'b1;
                            err_pulse <= 1'b1;
                            err_cnt   <= sat_inc(err_cnt);
                            if (RESYNC && is_odd) begin
                                expected  <= bus.count + STEP_W;
                                last_good <= bus.count;
                            end else if (RESYNC) begin
                                state  <= IDLE;
                                locked <= 1'b0;
                            end else begin
                                state  <= FAULT;
                                locked <= 1'b0;
                            end
                        end
                    end
                    FAULT: begin
                        // Sticky until clr or reset; samples are ignored.
                    end
                    default: begin
                        state  <= IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked;
    assign bus.err       = err;
    assign bus.err_pulse = err_pulse;
    assign bus.match_cnt = match_cnt;
    assign bus.err_cnt   = err_cnt;
    assign bus.last_good = last_good;

endmodule

// File: tb/tb_odd_count_checker.sv
// Scoreboard bench: directed samples push hand-computed expected outputs; a
// monitor per checker instance pops and compares one cycle after each sample.
module tb_odd_count_checker;

    typedef struct packed {
        logic        locked;
        logic        err;
        logic        pulse;
        logic [15:0] match;
        logic [15:0] ecnt;
        logic [31:0] last;
    } exp_t;

    logic clk;
    logic rst_l;

    odd_count_checker_if #(.WIDTH(32), .CNT_W(16)) bus1 ();
    odd_count_checker_if #(.WIDTH(32), .CNT_W(16)) bus0 ();

    odd_count_checker #(.WIDTH(32), .STEP(2), .CNT_W(16), .RESYNC(1'b1)) dut1 (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus1)
    );

    odd_count_checker #(.WIDTH(32), .STEP(2), .CNT_W(16), .RESYNC(1'b0)) dut0 (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    n_vec  = 0;
    int    n_miss = 0;
    exp_t  q1[$];
    exp_t  q0[$];
    string t1[$];
    string t0[$];
    int    issued1 = 0, taken1 = 0, popped1 = 0;
    int    issued0 = 0, taken0 = 0, popped0 = 0;

    function automatic exp_t mk(input logic l, input logic e, input logic p,
                                input int m, input int c, input logic [31:0] last);
        exp_t r;
        r.locked = l;
        r.err    = e;
        r.pulse  = p;
        r.match  = 16'(m);
        r.ecnt   = 16'(c);
        r.last   = last;
        return r;
    endfunction

    function automatic exp_t act1();
        return {bus1.locked, bus1.err, bus1.err_pulse, bus1.match_cnt, bus1.err_cnt, bus1.last_good};
    endfunction

    function automatic exp_t act0();
        return {bus0.locked, bus0.err, bus0.err_pulse, bus0.match_cnt, bus0.err_cnt, bus0.last_good};
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got L=%0b E=%0b P=%0b match=%0d errs=%0d last=%h, want L=%0b E=%0b P=%0b match=%0d errs=%0d last=%h",
                     name, got.locked, got.err, got.pulse, got.match, got.ecnt, got.last,
                     want.locked, want.err, want.pulse, want.match, want.ecnt, want.last);
        end
    endtask

    // Snapshot how many samples had been presented before this edge.
    always @(posedge clk) begin
        taken1 = issued1;
        taken0 = issued0;
    end

    always @(negedge clk) begin
        if (popped1 < taken1) begin
            popped1++;
            check(t1.pop_front(), act1(), q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (popped0 < taken0) begin
            popped0++;
            check(t0.pop_front(), act0(), q0.pop_front());
        end
    end

    task automatic idle();
        @(negedge clk);
        bus1.in_valid = 1'b0; bus1.clr = 1'b0;
        bus0.in_valid = 1'b0; bus0.clr = 1'b0;
    endtask

    task automatic apply(input int id, input string name, input logic clr,
                         input logic vld, input logic [31:0] cnt, input exp_t e);
        @(negedge clk);
        bus1.in_valid = 1'b0; bus1.clr = 1'b0;
        bus0.in_valid = 1'b0; bus0.clr = 1'b0;
        if (id == 1) begin
            bus1.clr = clr; bus1.in_valid = vld; bus1.count = cnt;
            q1.push_back(e); t1.push_back(name); issued1++;
        end else begin
            bus0.clr = clr; bus0.in_valid = vld; bus0.count = cnt;
            q0.push_back(e); t0.push_back(name); issued0++;
        end
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 10 && (popped1 < issued1 || popped0 < issued0); i++) @(negedge clk);
        #1;
        if (popped1 < issued1 || popped0 < issued0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: got %0d/%0d checks done, want all %0d/%0d", popped1, popped0, issued1, issued0);
        end
    endtask

    initial begin
        rst_l = 1'b0;
        bus1.in_valid = 1'b0; bus1.clr = 1'b0; bus1.count = '0;
        bus0.in_valid = 1'b0; bus0.clr = 1'b0; bus0.count = '0;
        #16;
        check("reset_r1", act1(), mk(0, 0, 0, 0, 0, 0));
        check("reset_r0", act0(), mk(0, 0, 0, 0, 0, 0));
        #4 rst_l = 1'b1;

        // Free-running 1..21: lock on 1, ten matches.
        apply(1, "run_lock", 0, 1, 32'd1, mk(1, 0, 0, 0, 0, 1));
        for (int k = 1; k <= 10; k++)
            apply(1, $sformatf("run_%0d", 1 + 2 * k), 0, 1, 32'(1 + 2 * k), mk(1, 0, 0, k, 0, 32'(1 + 2 * k)));
        apply(1, "clr_prio", 1, 1, 32'd99, mk(0, 0, 0, 0, 0, 0));

        // Skip 5: relock at 7, then an even value drops back to IDLE.
        apply(1, "skip_1", 0, 1, 32'd1,  mk(1, 0, 0, 0, 0, 1));
        apply(1, "skip_3", 0, 1, 32'd3,  mk(1, 0, 0, 1, 0, 3));
        apply(1, "skip_7", 0, 1, 32'd7,  mk(1, 1, 1, 1, 1, 7));
        apply(1, "skip_9", 0, 1, 32'd9,  mk(1, 1, 0, 2, 1, 9));
        apply(1, "skip_gap", 0, 0, 32'd0, mk(1, 1, 0, 2, 1, 9));
        apply(1, "track_even", 0, 1, 32'd10, mk(0, 1, 1, 2, 2, 9));
        apply(1, "clr_2", 1, 0, 32'd0, mk(0, 0, 0, 0, 0, 0));

        // Wrap through 2^32.
        apply(1, "wrap_fffd", 0, 1, 32'hFFFF_FFFD, mk(1, 0, 0, 0, 0, 32'hFFFF_FFFD));
        apply(1, "wrap_ffff", 0, 1, 32'hFFFF_FFFF, mk(1, 0, 0, 1, 0, 32'hFFFF_FFFF));
        apply(1, "wrap_1",    0, 1, 32'd1,         mk(1, 0, 0, 2, 0, 1));
        apply(1, "wrap_3",    0, 1, 32'd3,         mk(1, 0, 0, 3, 0, 3));
        apply(1, "clr_3", 1, 0, 32'd0, mk(0, 0, 0, 0, 0, 0));

        // Even first sample, then lock on 5.
        apply(1, "even_4", 0, 1, 32'd4, mk(0, 1, 1, 0, 1, 0));
        apply(1, "even_5", 0, 1, 32'd5, mk(1, 1, 0, 0, 1, 5));
        apply(1, "even_7", 0, 1, 32'd7, mk(1, 1, 0, 1, 1, 7));

        // No-resync instance: FAULT is sticky until clr.
        apply(0, "fault_5",  0, 1, 32'd5,  mk(1, 0, 0, 0, 0, 5));
        apply(0, "fault_7",  0, 1, 32'd7,  mk(1, 0, 0, 1, 0, 7));
        apply(0, "fault_8",  0, 1, 32'd8,  mk(0, 1, 1, 1, 1, 7));
        apply(0, "fault_11", 0, 1, 32'd11, mk(0, 1, 0, 1, 1, 7));
        apply(0, "fault_clr", 1, 0, 32'd0, mk(0, 0, 0, 0, 0, 0));
        apply(0, "fault_relock", 0, 1, 32'd1, mk(1, 0, 0, 0, 0, 1));

        // Gaps hold state; then async reset mid-TRACK.
        apply(1, "gap_a", 0, 0, 32'd123, mk(1, 1, 0, 1, 1, 7));
        apply(1, "gap_b", 0, 0, 32'd8,   mk(1, 1, 0, 1, 1, 7));
        apply(1, "gap_9", 0, 1, 32'd9,   mk(1, 1, 0, 2, 1, 9));
        drain();

        @(posedge clk);
        #2 rst_l = 1'b0;
        #1;
        check("async_rst_r1", act1(), mk(0, 0, 0, 0, 0, 0));
        check("async_rst_r0", act0(), mk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst_l = 1'b1;
        apply(1, "post_rst", 0, 1, 32'd7, mk(1, 0, 0, 0, 0, 7));
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
